// File: rtl/settle_pkg.sv
// settle_pkg: shared types and constants for the settlement unit.
// Holds the FSM state enum, coin values and the credit ceiling.
package settle_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE,
        S_REFUND
    } state_t;

    localparam logic [4:0] COIN1_VAL  = 5'd1;
    localparam logic [4:0] COIN5_VAL  = 5'd5;
    localparam logic [4:0] COIN10_VAL = 5'd10;

    localparam logic [5:0] CREDIT_MAX = 6'd63;

endpackage

// File: rtl/settle_seg_scan.sv
// settle_seg_scan: multiplexed 4-digit display of remaining and credit.
// Ports: clk, reset (sync, high); active enables the display;
//   remain/credit are 6-bit binary values shown in decimal;
//   show = active-low segments (dp,g,f,e,d,c,b,a), en = active-low digits.
import settle_pkg::*;

module settle_seg_scan #(
    parameter int DIGIT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic [5:0] remain,
    input  logic [5:0] credit,
    output logic [7:0] show,
    output logic [7:0] en
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [5:0]    r_ten, r_one, c_ten, c_one, dig;

    function automatic logic [5:0] tens_of(input logic [5:0] v);
        tens_of = 6'd0;
        for (int i = 1; i <= 6; i++) begin
            if (v >= 6'(10 * i)) tens_of = 6'(i);
        end
    endfunction

    function automatic logic [7:0] seg_of(input logic [5:0] d);
        unique case (d)
            6'd0:    seg_of = 8'hC0;
            6'd1:    seg_of = 8'hF9;
            6'd2:    seg_of = 8'hA4;
            6'd3:    seg_of = 8'hB0;
            6'd4:    seg_of = 8'h99;
            6'd5:    seg_of = 8'h92;
            6'd6:    seg_of = 8'h82;
            6'd7:    seg_of = 8'hF8;
            6'd8:    seg_of = 8'h80;
            6'd9:    seg_of = 8'h90;
            default: seg_of = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
            cnt_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_comb begin
        r_ten = tens_of(remain);
        r_one = remain - r_ten * 6'd10;
        c_ten = tens_of(credit);
        c_one = credit - c_ten * 6'd10;
        dig   = '0;
        unique case (idx_q)
            2'd0:    dig = r_one;
            2'd1:    dig = r_ten;
            2'd2:    dig = c_one;
            default: dig = c_ten;
        endcase
        show = 8'hFF;
        en   = 8'hFF;
        if (active) begin
            show = seg_of(dig);
            en   = ~(8'h01 << idx_q);
        end
    end

endmodule

// File: rtl/settle_unit.sv
// settle_unit: coin settlement FSM for a charging post, with display.
// Ports: clk, reset (sync, high); fin/charge open a settlement;
//   coin1/coin5/coin10/abort are level inputs counted on rising edges;
//   paid/refund pulse once, change holds the coins to return,
//   busy marks an open settlement, show/en drive the display.
// Build option: SETTLE_TIMEOUT_EN adds the idle-coin timeout.
import settle_pkg::*;

module settle_unit #(
    parameter int DIGIT_CYCLES   = 10000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fin,
    input  logic [3:0] charge,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       abort,
    output logic       paid,
    output logic       refund,
    output logic [5:0] change,
    output logic       busy,
    output logic [7:0] show,
    output logic [7:0] en
);

    state_t     state_q, state_d;
    logic [4:0] raw, in_q, in_p, rise;
    logic       armed;
    logic [3:0] charge_q, due_q, due_d;
    logic [5:0] credit_q, credit_d, change_q, change_d;
    logic [5:0] credit_add, remain;
    logic [6:0] credit_sum;
    logic [4:0] coin_sum;
    logic       coin_any, timeout;

    assign raw = {abort, coin10, coin5, coin1, fin};

    // For the first cycle after reset the history register copies the
    // live input, so a level already high at release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q     <= '0;
            in_p     <= '0;
            armed    <= 1'b0;
            charge_q <= '0;
        end else begin
            in_q     <= raw;
            in_p     <= armed ? in_q : raw;
            armed    <= 1'b1;
            charge_q <= charge;
        end
    end

    assign rise     = in_q & ~in_p;
    assign coin_any = |rise[3:1];
    assign coin_sum = ({5{rise[1]}} & COIN1_VAL)
                    + ({5{rise[2]}} & COIN5_VAL)
                    + ({5{rise[3]}} & COIN10_VAL);
    assign credit_sum = {1'b0, credit_q} + {2'b00, coin_sum};
    assign credit_add = (credit_sum > {1'b0, CREDIT_MAX})
                      ? CREDIT_MAX : credit_sum[5:0];
    assign remain = (credit_q >= {2'b00, due_q})
                  ? 6'd0 : {2'b00, due_q} - credit_q;

`ifdef SETTLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q;

    // tmr_q counts cycles since the last coin edge (1 the cycle after),
    // so refund lands TIMEOUT_CYCLES cycles after that edge.
    always_ff @(posedge clk) begin
        if (reset || state_q != S_COLLECT) begin
            tmr_q <= '0;
        end else if (coin_any) begin
            tmr_q <= TW'(1);
        end else begin
            tmr_q <= tmr_q + TW'(1);
        end
    end

    assign timeout = (state_q == S_COLLECT) && !coin_any
                  && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
`else
    // The limit has no effect unless the timeout build is selected.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            due_q    <= '0;
            credit_q <= '0;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            due_q    <= due_d;
            credit_q <= credit_d;
            change_q <= change_d;
        end
    end

    // change is loaded on the way into DONE/REFUND so it is already
    // valid in the cycle the paid/refund pulse is high.
    always_comb begin
        state_d  = state_q;
        due_d    = due_q;
        credit_d = credit_q;
        change_d = change_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise[0]) begin
                    state_d  = S_COLLECT;
                    due_d    = charge_q;
                    credit_d = '0;
                    change_d = '0;
                end
            end
            S_COLLECT: begin
                if (rise[4]) begin
                    state_d  = S_REFUND;
                    change_d = credit_q;
                end else if (credit_q >= {2'b00, due_q}) begin
                    state_d  = S_DONE;
                    change_d = credit_q - {2'b00, due_q};
                end else if (timeout) begin
                    state_d  = S_REFUND;
                    change_d = credit_q;
                end else begin
                    credit_d = credit_add;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign paid   = (state_q == S_DONE);
    assign refund = (state_q == S_REFUND);
    assign busy   = (state_q == S_COLLECT);
    assign change = change_q;

    settle_seg_scan #(
        .DIGIT_CYCLES(DIGIT_CYCLES)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .active(state_q != S_IDLE),
        .remain(remain),
        .credit(credit_q),
        .show  (show),
        .en    (en)
    );

endmodule
